// File: rtl/text_writer.sv
// text_writer: turns a stream of ASCII codes into writes to a COLS x ROWS
// character-tile RAM. It tracks a cursor, handles CR/LF/BS/FF, and clears
// a row on each new line and the whole screen on FF or reset.
module text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ch_valid,
  input  logic [6:0]  ch_data,
  output logic        ch_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [6:0]  wr_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] SPACE    = 7'h20;
  localparam logic [6:0] CODE_BS  = 7'h08;
  localparam logic [6:0] CODE_LF  = 7'h0A;
  localparam logic [6:0] CODE_FF  = 7'h0C;
  localparam logic [6:0] CODE_CR  = 7'h0D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_wr_en;
  logic [11:0] r_wr_addr;
  logic [6:0]  r_wr_data;
  logic [6:0]  r_cur_col;
  logic [4:0]  r_cur_row;
  logic [6:0]  r_clr_col;
  logic [4:0]  r_clr_row;
  // Set once the final clear write has been issued; the following cycle
  // returns to IDLE so ch_ready rises only after that write is visible.
  logic        r_clr_done;

  logic        w_accept;
  logic        w_printable;
  logic [4:0]  w_next_row;

  assign w_accept    = ch_valid && (r_state == IDLE);
  assign w_printable = (ch_data >= 7'h20) && (ch_data <= 7'h7E);
  assign w_next_row  = (r_cur_row == LAST_ROW) ? 5'd0 : r_cur_row + 5'd1;

  assign ch_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_cur_col;
  assign cursor_row = r_cur_row;

  // Single FSM: character decode in IDLE, clear sweeps in CLR_ROW/CLR_ALL.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= CLR_ALL;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 12'd0;
      r_wr_data  <= 7'd0;
      r_cur_col  <= 7'd0;
      r_cur_row  <= 5'd0;
      r_clr_col  <= 7'd0;
      r_clr_row  <= 5'd0;
      r_clr_done <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= {r_cur_row, r_cur_col};
              r_wr_data <= ch_data;
              if (r_cur_col == LAST_COL) begin
                r_cur_col  <= 7'd0;
                r_cur_row  <= w_next_row;
                r_clr_col  <= 7'd0;
                r_clr_done <= 1'b0;
                r_state    <= CLR_ROW;
              end else begin
                r_cur_col <= r_cur_col + 7'd1;
              end
            end else if (ch_data == CODE_CR) begin
              r_cur_col <= 7'd0;
            end else if (ch_data == CODE_LF) begin
              r_cur_col  <= 7'd0;
              r_cur_row  <= w_next_row;
              r_clr_col  <= 7'd0;
              r_clr_done <= 1'b0;
              r_state    <= CLR_ROW;
            end else if (ch_data == CODE_BS) begin
              if (r_cur_col != 7'd0) begin
                r_cur_col <= r_cur_col - 7'd1;
                r_wr_en   <= 1'b1;
                r_wr_addr <= {r_cur_row, r_cur_col - 7'd1};
                r_wr_data <= SPACE;
              end
            end else if (ch_data == CODE_FF) begin
              r_cur_col  <= 7'd0;
              r_cur_row  <= 5'd0;
              r_clr_col  <= 7'd0;
              r_clr_row  <= 5'd0;
              r_clr_done <= 1'b0;
              r_state    <= CLR_ALL;
            end
          end
        end
        CLR_ROW: begin
          if (r_clr_done) begin
            r_clr_done <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_cur_row, r_clr_col};
            r_wr_data <= SPACE;
            if (r_clr_col == LAST_COL) begin
              r_clr_col  <= 7'd0;
              r_clr_done <= 1'b1;
            end else begin
              r_clr_col <= r_clr_col + 7'd1;
            end
          end
        end
        CLR_ALL: begin
          if (r_clr_done) begin
            r_clr_done <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_clr_row, r_clr_col};
            r_wr_data <= SPACE;
            if (r_clr_col == LAST_COL) begin
              r_clr_col <= 7'd0;
              if (r_clr_row == LAST_ROW) begin
                r_clr_row  <= 5'd0;
                r_clr_done <= 1'b1;
              end else begin
                r_clr_row <= r_clr_row + 5'd1;
              end
            end else begin
              r_clr_col <= r_clr_col + 7'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
